fifo_reader: RTL and testbench
==============================

Name: fifo_reader

Overview:
- Read-side master for the 32x8 FIFO.
- On a START command it drains exactly LEN words from the FIFO read port and presents them on a valid/ready output stream.
- Absorbs the FIFO's 1-cycle read latency and output back-pressure with a 2-entry skid buffer, so reads never lose data.
- Sits between the FIFO's DATA_OUT side and any downstream consumer; it is the counterpart of the write-side stimulus that fills the FIFO.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- DEPTH, 32, FIFO depth; bounds LEN.
- CNT_W, $clog2(DEPTH)+1 = 6, width of length and word counters.

Ports:
- CLOCK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle transfer request; ignored while BUSY.
- LEN  in  CNT_W  words to drain; sampled with START; legal range 0..DEPTH.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse at end of transfer.
- WORD_CNT  out  CNT_W  output handshakes completed in current transfer.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_READ  out  1  FIFO read strobe, one word per cycle high.
- FIFO_DATA_OUT  in  DATA_WIDTH  FIFO read data, valid the cycle after FIFO_READ.
- M_DATA  out  DATA_WIDTH  output word.
- M_VALID  out  1  M_DATA valid.
- M_READY  in  1  consumer accepts word when M_VALID && M_READY.

Behaviour:
- Reset values, applied asynchronously while RESET_N=0:
  - Outputs: BUSY=0, DONE=0, WORD_CNT=0, FIFO_READ=0, M_VALID=0, M_DATA=0.
  - Internal state: skid buffer empty, inflight=0, state=IDLE.
- Reset mid-transfer aborts the transfer. No DONE is produced, and words already popped from the FIFO are lost.
- FSM states: IDLE, DRAIN, FLUSH.
- IDLE:
  - START with LEN!=0: go to DRAIN; req_left<=LEN; WORD_CNT<=0; BUSY=1 from the next cycle.
  - START with LEN==0: stay IDLE; DONE=1 for one cycle, the next cycle.
- DRAIN:
  - FIFO_READ = !FIFO_EMPTY && req_left!=0 && (buf_count + inflight - pop) < 2, where pop = M_VALID && M_READY.
  - FIFO_READ is combinational in this cycle.
  - Each FIFO_READ decrements req_left and sets inflight for one cycle. The word on FIFO_DATA_OUT is written into the buffer at the end of the following cycle.
  - Go to FLUSH when req_left reaches 0.
  - FIFO_EMPTY=1 only stalls the read; no timeout.
- FLUSH:
  - No FIFO_READ.
  - When buf_count==0 and inflight==0: DONE=1 and BUSY=0 for one cycle, then IDLE.
- Output stream:
  - M_VALID = (buf_count != 0); M_DATA = buffer head.
  - While M_VALID && !M_READY, M_DATA and M_VALID hold stable.
  - WORD_CNT increments on each handshake and saturates at LEN.
  - Words leave in FIFO order.
- Latency:
  - START in cycle 0 gives FIFO_READ in cycle 1, FIFO data in cycle 2, and M_VALID in cycle 3.
  - With M_READY=1 and the FIFO non-empty: one word per cycle sustained.
  - DONE fires in the cycle after the last handshake.
- Simultaneous events:
  - Buffer pop and write in the same cycle keep buf_count unchanged.
  - START while BUSY is ignored and does not alter LEN.
- Width rules: buf_count is 2 bits (0..2); LEN > DEPTH is out of contract.

Decomposition:
- Package fifo_pkg holds:
  - DATA_WIDTH=8, DEPTH=32, CNT_W.
  - typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} rd_state_t.
  - typedef logic [DATA_WIDTH-1:0] data_t.
- One sub-module, fifo_rd_skid: a 2-entry FIFO-ordered buffer.
  - Ports: push, push_data, pop, head, count.
- The FSM and counters stay in fifo_reader.

Test Plan:
1. FIFO preloaded with 8'h11, 8'h22, 8'h33; START with LEN=3; M_READY=1 → M_DATA sequence 11, 22, 33 on consecutive cycles starting 3 cycles after START; DONE pulse once; WORD_CNT=3.
2. FIFO holds 5 words; LEN=5; M_READY toggles 1,0,0,1,... → no word lost or duplicated; M_DATA stable while stalled; FIFO_READ never drives buffer occupancy above 2.
3. FIFO empty at START with LEN=2; write 8'hA5 after 4 cycles and 8'h5A after 10 cycles → FIFO_READ only when FIFO_EMPTY=0; outputs A5, 5A; DONE after second handshake.
4. LEN=0 → DONE pulse in the next cycle; FIFO_READ never asserted; BUSY stays 0.
5. FIFO full (32 words 0..31); LEN=32; M_READY=1 → FIFO ends EMPTY; outputs 0..31 in order; WORD_CNT=32; START pulsed mid-transfer is ignored.
6. RESET_N=0 during DRAIN after 2 of 4 words → all outputs 0 immediately; state IDLE; no DONE; a fresh START with LEN=2 reads the remaining FIFO words correctly.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side master.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned DEPTH      = 32;
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH
    } rd_state_t;

    typedef logic [DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry FIFO-ordered skid buffer. Entry 0 is always the head.
// The caller guarantees no push when full and no pop when empty.
module fifo_rd_skid
    import fifo_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  data_t      i_push_data,
    input  logic       i_pop,
    output data_t      o_head,
    output logic [1:0] o_count
);

    data_t      r_ent0;
    data_t      r_ent1;
    logic [1:0] r_count;

    // Storage and occupancy update; simultaneous push and pop keeps the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ent0  <= '0;
            r_ent1  <= '0;
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_ent0 <= i_push_data;
                    end else begin
                        r_ent1 <= i_push_data;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_ent0 <= i_push_data;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_head  = r_ent0;
    assign o_count = r_count;

endmodule

// File: rtl/fifo_reader.sv
// Read-side master: on START drains LEN words from the FIFO read port and
// streams them out on a valid/ready interface through a 2-entry skid buffer
// that absorbs the FIFO's 1-cycle read latency and output back-pressure.
module fifo_reader
    import fifo_pkg::*;
(
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_word_cnt,
    input  logic             i_fifo_empty,
    output logic             o_fifo_read,
    input  data_t            i_fifo_data_out,
    output data_t            o_m_data,
    output logic             o_m_valid,
    input  logic             i_m_ready
);

    rd_state_t        r_state;
    rd_state_t        w_next_state;
    logic [CNT_W-1:0] r_req_left;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_word_cnt;
    logic             r_inflight;
    logic             r_done_zero;

    logic             w_read;
    logic             w_flush_done;
    logic             w_pop;
    logic             w_valid;
    logic [1:0]       w_count;
    logic [2:0]       w_occ;
    data_t            w_head;

    fifo_rd_skid u_skid (
        .i_clk       (i_clock),
        .i_rst_n     (i_reset_n),
        .i_push      (r_inflight),
        .i_push_data (i_fifo_data_out),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign w_valid = (w_count != 2'd0);
    assign w_pop   = w_valid && i_m_ready;
    // Occupancy the buffer will hold once this cycle's pop and the in-flight word settle.
    assign w_occ   = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);

    // Next-state and read-strobe decode.
    always_comb begin
        w_next_state = r_state;
        w_read       = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start && (i_len != '0)) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!i_fifo_empty && (r_req_left != '0) && (w_occ < 3'd2)) begin
                    w_read = 1'b1;
                end
                if ((r_req_left == '0) || (w_read && (r_req_left == CNT_W'(1)))) begin
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                if ((w_count == 2'd0) && !r_inflight) begin
                    w_flush_done = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transfer bookkeeping: request/length/handshake counters and read-latency tracking.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_req_left  <= '0;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_done_zero <= 1'b0;
        end else begin
            r_inflight  <= w_read;
            r_done_zero <= (r_state == IDLE) && i_start && (i_len == '0);
            if ((r_state == IDLE) && i_start) begin
                r_req_left <= i_len;
                r_len      <= i_len;
                r_word_cnt <= '0;
            end else begin
                if (w_read) begin
                    r_req_left <= r_req_left - CNT_W'(1);
                end
                if (w_pop && (r_word_cnt != r_len)) begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_busy      = (r_state != IDLE) && !w_flush_done;
    assign o_done      = r_done_zero || w_flush_done;
    assign o_word_cnt  = r_word_cnt;
    assign o_fifo_read = w_read;
    assign o_m_valid   = w_valid;
    assign o_m_data    = w_head;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a queue-based FIFO and an output-order model.
module tb_fifo_reader;
    import fifo_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_start;
    logic [CNT_W-1:0] i_len;
    logic             o_busy;
    logic             o_done;
    logic [CNT_W-1:0] o_word_cnt;
    logic             i_fifo_empty;
    logic             o_fifo_read;
    logic [7:0]       i_fifo_data_out;
    logic [7:0]       o_m_data;
    logic             o_m_valid;
    logic             i_m_ready;

    fifo_reader dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_start         (i_start),
        .i_len           (i_len),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_word_cnt      (o_word_cnt),
        .i_fifo_empty    (i_fifo_empty),
        .o_fifo_read     (o_fifo_read),
        .i_fifo_data_out (i_fifo_data_out),
        .o_m_data        (o_m_data),
        .o_m_valid       (o_m_valid),
        .i_m_ready       (i_m_ready)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural FIFO (read data one cycle after the strobe)
    logic [7:0] fq[$];
    logic [7:0] popped_q[$];
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_seen = 1'b0;

    initial begin
        i_fifo_empty    = 1'b1;
        i_fifo_data_out = '0;
    end

    always @(posedge clk) begin
        if (rd_seen && fq.size() != 0) begin
            i_fifo_data_out <= fq[0];
            popped_q.push_back(fq[0]);
            void'(fq.pop_front());
        end
        if (wr_en) fq.push_back(wr_data);
        i_fifo_empty <= (fq.size() == 0);
    end

    // ---------------- transfer model and per-cycle compare
    logic       m_active = 1'b0;
    logic       m_done_pend = 1'b0;
    int unsigned m_len = 0;
    int unsigned m_wc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic       exp_done;
    logic       was_active;
    logic [7:0] hs_data[$];
    int unsigned hs_cyc[$];
    int unsigned done_cyc[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            popped_q.delete();
            m_active    = 1'b0;
            m_done_pend = 1'b0;
            m_wc        = 0;
            prev_stall  = 1'b0;
            rd_seen     = 1'b0;
        end else begin
            rd_seen    = o_fifo_read;
            exp_done   = m_done_pend;
            was_active = m_active;
            chk("done", o_done, exp_done);
            chk("busy", o_busy, m_active && !exp_done);
            if (m_active) chk("word_cnt", o_word_cnt, m_wc);
            chk("read_legal", o_fifo_read && (i_fifo_empty || !m_active), 0);
            chk("occupancy_le2", (popped_q.size() > 2) ? 1 : 0, 0);
            if (o_done) done_cyc.push_back(cyc);
            if (exp_done) begin
                m_active    = 1'b0;
                m_done_pend = 1'b0;
            end
            if (prev_stall) begin
                chk("stall_valid", o_m_valid, 1);
                chk("stall_data", o_m_data, prev_data);
            end
            if (o_m_valid && i_m_ready) begin
                chk("hs_in_xfer", was_active, 1);
                chk("hs_has_word", popped_q.size() != 0, 1);
                if (popped_q.size() != 0) chk("hs_data", o_m_data, popped_q.pop_front());
                hs_data.push_back(o_m_data);
                hs_cyc.push_back(cyc);
                if (m_wc < m_len) m_wc++;
                if (m_wc == m_len) m_done_pend = 1'b1;
            end
            prev_stall = o_m_valid && !i_m_ready;
            prev_data  = o_m_data;
            if (i_start && !was_active) begin
                if (i_len == '0) begin
                    m_done_pend = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_len    = i_len;
                    m_wc     = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_write(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_xfer(input logic [CNT_W-1:0] len, output int unsigned s);
        i_start = 1'b1;
        i_len   = len;
        s       = cyc;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned limit, input string nm);
        int unsigned n0;
        int unsigned k;
        n0 = done_cyc.size();
        k  = 0;
        while (done_cyc.size() == n0 && k < limit) begin
            tick();
            k++;
        end
        chk(nm, done_cyc.size() > n0, 1);
    endtask

    task automatic clear_logs();
        hs_data.delete();
        hs_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},   o_busy, 0);
        chk({tag, "_done"},   o_done, 0);
        chk({tag, "_wcnt"},   o_word_cnt, 0);
        chk({tag, "_fread"},  o_fifo_read, 0);
        chk({tag, "_mvalid"}, o_m_valid, 0);
        chk({tag, "_mdata"},  o_m_data, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s;
        int unsigned k;
        int unsigned n0;
        logic [7:0] e1 [3];
        logic [7:0] e2 [5];

        rst_n     = 1'b0;
        i_start   = 1'b0;
        i_len     = '0;
        i_m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        tick();

        // 1: three words, full-rate consumer, exact latency.
        e1 = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) fifo_write(e1[i]);
        clear_logs();
        start_xfer(6'd3, s);
        wait_done(40, "t1_done_seen");
        chk("t1_count", hs_data.size(), 3);
        for (int i = 0; i < 3 && i < hs_data.size(); i++) begin
            chk("t1_data", hs_data[i], e1[i]);
            chk("t1_cycle", hs_cyc[i], s + 3 + i);
        end
        if (done_cyc.size() != 0) chk("t1_done_cycle", done_cyc[0], s + 6);
        chk("t1_word_cnt", o_word_cnt, 3);
        repeat (3) tick();
        chk("t1_single_done", done_cyc.size(), 1);

        // 2: back-pressure pattern 1,0,0,1.
        e2 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
        for (int i = 0; i < 5; i++) fifo_write(e2[i]);
        clear_logs();
        start_xfer(6'd5, s);
        n0 = done_cyc.size();
        for (k = 0; k < 80 && done_cyc.size() == n0; k++) begin
            i_m_ready = ((k % 4) == 0) || ((k % 4) == 3);
            tick();
        end
        i_m_ready = 1'b1;
        chk("t2_done_seen", done_cyc.size() > n0, 1);
        chk("t2_count", hs_data.size(), 5);
        for (int i = 0; i < 5 && i < hs_data.size(); i++) chk("t2_data", hs_data[i], e2[i]);
        chk("t2_word_cnt", o_word_cnt, 5);
        tick();

        // 3: FIFO empty at start, words trickle in.
        clear_logs();
        start_xfer(6'd2, s);
        repeat (3) tick();
        fifo_write(8'hA5);
        repeat (5) tick();
        fifo_write(8'h5A);
        wait_done(40, "t3_done_seen");
        chk("t3_count", hs_data.size(), 2);
        if (hs_data.size() == 2) begin
            chk("t3_data0", hs_data[0], 8'hA5);
            chk("t3_data1", hs_data[1], 8'h5A);
            if (done_cyc.size() != 0) chk("t3_done_cycle", done_cyc[0], hs_cyc[1] + 1);
        end
        tick();

        // 4: zero-length transfer.
        clear_logs();
        start_xfer(6'd0, s);
        wait_done(5, "t4_done_seen");
        if (done_cyc.size() != 0) chk("t4_done_cycle", done_cyc[0], s + 1);
        chk("t4_no_words", hs_data.size(), 0);
        chk("t4_busy", o_busy, 0);
        tick();

        // 5: full FIFO, LEN=DEPTH, START pulsed mid-transfer.
        for (int i = 0; i < 32; i++) fifo_write(8'(i));
        clear_logs();
        start_xfer(6'd32, s);
        repeat (10) tick();
        i_start = 1'b1;
        i_len   = 6'd5;
        tick();
        i_start = 1'b0;
        wait_done(100, "t5_done_seen");
        chk("t5_count", hs_data.size(), 32);
        for (int i = 0; i < 32 && i < hs_data.size(); i++) chk("t5_data", hs_data[i], 8'(i));
        chk("t5_word_cnt", o_word_cnt, 32);
        chk("t5_fifo_drained", fq.size(), 0);
        chk("t5_busy", o_busy, 0);
        tick();

        // 6: reset after 2 of 4 words; remaining FIFO words read by a fresh transfer.
        for (int i = 0; i < 6; i++) fifo_write(8'hC1 + 8'(i));
        clear_logs();
        start_xfer(6'd4, s);
        for (k = 0; k < 40 && hs_data.size() < 2; k++) tick();
        chk("t6_two_words", hs_data.size(), 2);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("t6_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("t6_no_done", done_cyc.size(), 0);
        clear_logs();
        start_xfer(6'd2, s);
        wait_done(40, "t6_done_seen");
        chk("t6_count", hs_data.size(), 2);
        if (hs_data.size() == 2) begin
            chk("t6_data0", hs_data[0], 8'hC5);
            chk("t6_data1", hs_data[1], 8'hC6);
        end
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
